// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, MIPS
// opcode/func fields, ALU operation codes and datapath mux selects.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;

    // ALU operations; the MSB only matters for shifts
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // ALU B operand select
    localparam logic [1:0] ASB_REG  = 2'b00;
    localparam logic [1:0] ASB_FOUR = 2'b01;
    localparam logic [1:0] ASB_IMM  = 2'b10;
    localparam logic [1:0] ASB_BR   = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_BT  = 2'b01;
    localparam logic [1:0] PCS_RA  = 2'b10;
    localparam logic [1:0] PCS_JMP = 2'b11;

    // One-hot instruction flags produced by the decoder
    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lui;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_j;
        logic i_jal;
    } inst_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decoder. Produces one-hot instruction flags and a
// legal flag; anything outside the supported subset decodes to all zeros.
module mc_decode
    import mc_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output inst_t      inst,
    output logic       legal
);

    logic r;

    assign r = (op == OP_R);

    // Match every supported instruction against its op/func pattern
    always_comb begin
        inst        = '0;
        inst.i_add  = r && (func == F_ADD);
        inst.i_sub  = r && (func == F_SUB);
        inst.i_and  = r && (func == F_AND);
        inst.i_or   = r && (func == F_OR);
        inst.i_xor  = r && (func == F_XOR);
        inst.i_sll  = r && (func == F_SLL);
        inst.i_srl  = r && (func == F_SRL);
        inst.i_sra  = r && (func == F_SRA);
        inst.i_jr   = r && (func == F_JR);
        inst.i_addi = (op == OP_ADDI);
        inst.i_andi = (op == OP_ANDI);
        inst.i_ori  = (op == OP_ORI);
        inst.i_xori = (op == OP_XORI);
        inst.i_lui  = (op == OP_LUI);
        inst.i_lw   = (op == OP_LW);
        inst.i_sw   = (op == OP_SW);
        inst.i_beq  = (op == OP_BEQ);
        inst.i_bne  = (op == OP_BNE);
        inst.i_j    = (op == OP_J);
        inst.i_jal  = (op == OP_JAL);
    end

    assign legal = |inst;

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: sequences the shared ALU and unified memory
// through IF/ID/EXE/MEM/WB and counts retired instructions.
//
// state | meaning
// ------+-----------------------------------------------------------
// IF  0 | fetch at PC, PC+4 via ALU; waits on mem_ready
// ID    | branch target into target reg; j/jal/jr finish here
// EXE   | ALU op; branches resolve and finish here
// MEM   | data access at ALU result; waits on mem_ready
// WB    | register-file write from ALU result or memory data
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_ready,
    output logic             wpc,
    output logic             wir,
    output logic             wmem,
    output logic             wreg,
    output logic             iord,
    output logic             regrt,
    output logic             m2reg,
    output logic             jal,
    output logic             shift,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             sext,
    output logic [3:0]       aluc,
    output logic [1:0]       pcsource,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t st_q;
    state_t st_n;
    inst_t  ins;
    logic   legal;
    logic   pc_we, ir_we, mem_we, reg_we;
    logic   r_alu, shifts, i_wb, taken;

    mc_decode u_dec (
        .op    (op),
        .func  (func),
        .inst  (ins),
        .legal (legal)
    );

    assign shifts = ins.i_sll | ins.i_srl | ins.i_sra;
    assign r_alu  = ins.i_add | ins.i_sub | ins.i_and | ins.i_or | ins.i_xor | shifts;
    assign i_wb   = ins.i_addi | ins.i_andi | ins.i_ori | ins.i_xori | ins.i_lui | ins.i_lw;
    assign taken  = (ins.i_beq & z) | (ins.i_bne & ~z);

    // Next state and all datapath controls, decoded from state and IR
    always_comb begin
        st_n     = S_IF;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ASB_FOUR;
        sext     = 1'b0;
        aluc     = ALU_ADD;
        pcsource = PCS_ALU;
        illegal  = 1'b0;
        case (st_q)
            S_IF: begin
                ir_we = mem_ready;
                pc_we = mem_ready;
                st_n  = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                alusrcb = ASB_BR;
                if (ins.i_j || ins.i_jal) begin
                    pc_we    = 1'b1;
                    pcsource = PCS_JMP;
                    reg_we   = ins.i_jal;
                    jal      = ins.i_jal;
                    st_n     = S_IF;
                end else if (ins.i_jr) begin
                    pc_we    = 1'b1;
                    pcsource = PCS_RA;
                    st_n     = S_IF;
                end else if (!legal) begin
                    illegal = 1'b1;
                    st_n    = S_IF;
                end else begin
                    st_n = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                shift   = shifts;
                alusrcb = (r_alu || ins.i_beq || ins.i_bne) ? ASB_REG : ASB_IMM;
                sext    = ins.i_addi | ins.i_lw | ins.i_sw | ins.i_beq | ins.i_bne;
                if (ins.i_sub || ins.i_beq || ins.i_bne) aluc = ALU_SUB;
                else if (ins.i_and || ins.i_andi)        aluc = ALU_AND;
                else if (ins.i_or  || ins.i_ori)         aluc = ALU_OR;
                else if (ins.i_xor || ins.i_xori)        aluc = ALU_XOR;
                else if (ins.i_lui)                      aluc = ALU_LUI;
                else if (ins.i_sll)                      aluc = ALU_SLL;
                else if (ins.i_srl)                      aluc = ALU_SRL;
                else if (ins.i_sra)                      aluc = ALU_SRA;
                if (ins.i_beq || ins.i_bne) begin
                    pc_we    = taken;
                    pcsource = PCS_BT;
                    st_n     = S_IF;
                end else if (ins.i_lw || ins.i_sw) begin
                    st_n = S_MEM;
                end else begin
                    st_n = S_WB;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (ins.i_sw) begin
                    mem_we = mem_ready;
                    st_n   = mem_ready ? S_IF : S_MEM;
                end else if (ins.i_lw) begin
                    st_n = mem_ready ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                regrt  = i_wb;
                m2reg  = ins.i_lw;
            end
            default: st_n = S_IF;
        endcase
    end

    // Write enables are held off combinationally for the whole reset so an
    // aborted instruction can never disturb PC, IR, memory or registers
    assign wpc  = pc_we  & resetn;
    assign wir  = ir_we  & resetn;
    assign wmem = mem_we & resetn;
    assign wreg = reg_we & resetn;

    assign state = st_q;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) st_q <= S_IF;
        else         st_q <= st_n;
    end

    // Retire count: one per return to IF from any instruction-executing state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            retired <= '0;
        else if (st_n == S_IF && (st_q inside {S_ID, S_EXE, S_MEM, S_WB}))
            retired <= retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_mc_cu.sv
// Directed scoreboard bench for mc_cu: each step queues the hand-computed
// outputs for that cycle; the monitor compares them on the falling edge.
module tb_mc_cu;

    localparam logic [5:0] OR_  = 6'b000000, OJ  = 6'b000010, OJAL = 6'b000011;
    localparam logic [5:0] OBEQ = 6'b000100, OBNE = 6'b000101, OORI = 6'b001101;
    localparam logic [5:0] OLUI = 6'b001111, OLW = 6'b100011, OSW  = 6'b101011;
    localparam logic [5:0] FADD = 6'b100000, FSLL = 6'b000000, FJR = 6'b001000;
    localparam logic [2:0] SIF = 3'd0, SID = 3'd1, SEX = 3'd2, SME = 3'd3, SWB = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca;
        logic [1:0] alusrcb;
        logic       sext;
        logic [3:0] aluc;
        logic [1:0] pcsource;
        logic       illegal;
    } obs_t;

    typedef struct {
        string       nm;
        obs_t        v;
        obs_t        m;
        logic [31:0] ret;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic [5:0]  op, func;
    logic        z, mem_ready;
    logic        wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca, sext, illegal;
    logic [1:0]  alusrcb, pcsource;
    logic [3:0]  aluc;
    logic [2:0]  state;
    logic [31:0] retired;

    obs_t act, xv, xm;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    mc_cu #(.CNT_W(32)) dut (
        .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z),
        .mem_ready(mem_ready), .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg),
        .iord(iord), .regrt(regrt), .m2reg(m2reg), .jal(jal), .shift(shift),
        .alusrca(alusrca), .alusrcb(alusrcb), .sext(sext), .aluc(aluc),
        .pcsource(pcsource), .state(state), .illegal(illegal), .retired(retired)
    );

    assign act = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift,
                  alusrca, alusrcb, sext, aluc, pcsource, illegal};

    // Monitor: pop the expectation for this cycle and compare
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (((act ^ e.v) & e.m) !== '0) begin
                n_bad++;
                $display("FAIL %s: outputs got %h want %h under mask %h (t=%0t)",
                         e.nm, act, e.v & e.m, e.m, $time);
            end
            n_cmp++;
            if (retired !== e.ret) begin
                n_bad++;
                $display("FAIL %s retired: got %0d want %0d", e.nm, retired, e.ret);
            end
        end
    end

    // Apply one cycle of inputs and queue the expected outputs for it;
    // extra fields selected in xv/xm beforehand are checked as well
    task automatic step(input string nm, input logic [5:0] o, input logic [5:0] f,
                        input logic zz, input logic mr, input logic [2:0] st,
                        input logic [3:0] we, input logic ill, input int ret);
        exp_t e;
        op = o; func = f; z = zz; mem_ready = mr;
        e.nm = nm;
        e.v = xv;
        e.m = xm;
        e.v.st = st;
        e.m.st = '1;
        {e.v.wpc, e.v.wir, e.v.wmem, e.v.wreg} = we;
        {e.m.wpc, e.m.wir, e.m.wmem, e.m.wreg} = 4'hf;
        e.v.illegal = ill;
        e.m.illegal = 1'b1;
        e.ret = 32'(ret);
        q.push_back(e);
        xv = '0;
        xm = '0;
        @(negedge clock);
        #1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        xv = '0; xm = '0;
        resetn = 1'b0; op = '0; func = '0; z = 1'b0; mem_ready = 1'b0;
        #2;
        // held in reset: enables forced low even though mem_ready is high
        step("rst_hold", OR_, FADD, 0, 1, SIF, 4'b0000, 0, 0);
        resetn = 1'b1;
        r = 0;

        // add $3,$1,$2 with one fetch stall
        step("add_if_stall", OR_, FADD, 0, 0, SIF, 4'b0000, 0, r);
        xm.iord = 1; xm.alusrca = 1; xm.alusrcb = '1; xm.aluc = '1; xm.pcsource = '1;
        xv.alusrcb = 2'b01;
        step("add_if", OR_, FADD, 0, 1, SIF, 4'b1100, 0, r);
        xm.alusrca = 1; xm.alusrcb = '1; xm.aluc = '1;
        xv.alusrcb = 2'b11;
        step("add_id", OR_, FADD, 0, 1, SID, 4'b0000, 0, r);
        xm.alusrca = 1; xm.alusrcb = '1; xm.shift = 1; xm.aluc = '1;
        xv.alusrca = 1;
        step("add_exe", OR_, FADD, 0, 1, SEX, 4'b0000, 0, r);
        xm.regrt = 1; xm.m2reg = 1;
        step("add_wb", OR_, FADD, 0, 1, SWB, 4'b0001, 0, r);
        r++;

        // sll
        step("sll_if", OR_, FSLL, 0, 1, SIF, 4'b1100, 0, r);
        step("sll_id", OR_, FSLL, 0, 1, SID, 4'b0000, 0, r);
        xm.shift = 1; xm.aluc = '1; xv.shift = 1; xv.aluc = 4'b0011;
        step("sll_exe", OR_, FSLL, 0, 1, SEX, 4'b0000, 0, r);
        step("sll_wb", OR_, FSLL, 0, 1, SWB, 4'b0001, 0, r);
        r++;

        // lw with two wait cycles in MEM: 7 cycles total
        step("lw_if", OLW, 6'h04, 0, 1, SIF, 4'b1100, 0, r);
        step("lw_id", OLW, 6'h04, 0, 1, SID, 4'b0000, 0, r);
        xm.alusrcb = '1; xm.sext = 1; xm.aluc = '1;
        xv.alusrcb = 2'b10; xv.sext = 1;
        step("lw_exe", OLW, 6'h04, 0, 1, SEX, 4'b0000, 0, r);
        xm.iord = 1; xv.iord = 1;
        step("lw_mem_w1", OLW, 6'h04, 0, 0, SME, 4'b0000, 0, r);
        step("lw_mem_w2", OLW, 6'h04, 0, 0, SME, 4'b0000, 0, r);
        step("lw_mem_rdy", OLW, 6'h04, 0, 1, SME, 4'b0000, 0, r);
        xm.regrt = 1; xm.m2reg = 1; xv.regrt = 1; xv.m2reg = 1;
        step("lw_wb", OLW, 6'h04, 0, 1, SWB, 4'b0001, 0, r);
        r++;

        // sw with one wait cycle
        step("sw_if", OSW, 6'h08, 0, 1, SIF, 4'b1100, 0, r);
        step("sw_id", OSW, 6'h08, 0, 1, SID, 4'b0000, 0, r);
        xm.sext = 1; xv.sext = 1;
        step("sw_exe", OSW, 6'h08, 0, 1, SEX, 4'b0000, 0, r);
        step("sw_mem_w", OSW, 6'h08, 0, 0, SME, 4'b0000, 0, r);
        xm.iord = 1; xv.iord = 1;
        step("sw_mem_rdy", OSW, 6'h08, 0, 1, SME, 4'b0010, 0, r);
        r++;

        // beq taken / not taken, bne taken
        step("beq1_if", OBEQ, 6'h01, 1, 1, SIF, 4'b1100, 0, r);
        step("beq1_id", OBEQ, 6'h01, 1, 1, SID, 4'b0000, 0, r);
        xm.pcsource = '1; xm.aluc = '1; xm.alusrcb = '1; xm.sext = 1;
        xv.pcsource = 2'b01; xv.aluc = 4'b0100; xv.sext = 1;
        step("beq_taken_exe", OBEQ, 6'h01, 1, 1, SEX, 4'b1000, 0, r);
        r++;
        step("beq0_if", OBEQ, 6'h01, 0, 1, SIF, 4'b1100, 0, r);
        step("beq0_id", OBEQ, 6'h01, 0, 1, SID, 4'b0000, 0, r);
        step("beq_nt_exe", OBEQ, 6'h01, 0, 1, SEX, 4'b0000, 0, r);
        r++;
        step("bne_if", OBNE, 6'h01, 0, 1, SIF, 4'b1100, 0, r);
        step("bne_id", OBNE, 6'h01, 0, 1, SID, 4'b0000, 0, r);
        xm.pcsource = '1; xv.pcsource = 2'b01;
        step("bne_taken_exe", OBNE, 6'h01, 0, 1, SEX, 4'b1000, 0, r);
        r++;

        // jal, jr, j finish in ID
        step("jal_if", OJAL, 6'h10, 0, 1, SIF, 4'b1100, 0, r);
        xm.pcsource = '1; xm.jal = 1; xv.pcsource = 2'b11; xv.jal = 1;
        step("jal_id", OJAL, 6'h10, 0, 1, SID, 4'b1001, 0, r);
        r++;
        step("jr_if", OR_, FJR, 0, 1, SIF, 4'b1100, 0, r);
        xm.pcsource = '1; xv.pcsource = 2'b10;
        step("jr_id", OR_, FJR, 0, 1, SID, 4'b1000, 0, r);
        r++;
        step("j_if", OJ, 6'h20, 0, 1, SIF, 4'b1100, 0, r);
        xm.pcsource = '1; xv.pcsource = 2'b11;
        step("j_id", OJ, 6'h20, 0, 1, SID, 4'b1000, 0, r);
        r++;

        // undecoded opcode and undecoded R-type func
        step("ill_op_if", 6'b111111, 6'h00, 0, 1, SIF, 4'b1100, 0, r);
        step("ill_op_id", 6'b111111, 6'h00, 0, 1, SID, 4'b0000, 1, r);
        r++;
        step("ill_fn_if", OR_, 6'b111111, 0, 1, SIF, 4'b1100, 0, r);
        step("ill_fn_id", OR_, 6'b111111, 0, 1, SID, 4'b0000, 1, r);
        r++;

        // ori (zero-extended) and lui
        step("ori_if", OORI, 6'h3f, 0, 1, SIF, 4'b1100, 0, r);
        step("ori_id", OORI, 6'h3f, 0, 1, SID, 4'b0000, 0, r);
        xm.alusrcb = '1; xm.sext = 1; xm.aluc = '1;
        xv.alusrcb = 2'b10; xv.aluc = 4'b0101;
        step("ori_exe", OORI, 6'h3f, 0, 1, SEX, 4'b0000, 0, r);
        xm.regrt = 1; xm.m2reg = 1; xv.regrt = 1;
        step("ori_wb", OORI, 6'h3f, 0, 1, SWB, 4'b0001, 0, r);
        r++;
        step("lui_if", OLUI, 6'h00, 0, 1, SIF, 4'b1100, 0, r);
        step("lui_id", OLUI, 6'h00, 0, 1, SID, 4'b0000, 0, r);
        xm.aluc = '1; xv.aluc = 4'b0110;
        step("lui_exe", OLUI, 6'h00, 0, 1, SEX, 4'b0000, 0, r);
        xm.regrt = 1; xv.regrt = 1;
        step("lui_wb", OLUI, 6'h00, 0, 1, SWB, 4'b0001, 0, r);
        r++;

        // reset asserted while add sits in EXE
        step("add2_if", OR_, FADD, 0, 1, SIF, 4'b1100, 0, r);
        step("add2_id", OR_, FADD, 0, 1, SID, 4'b0000, 0, r);
        resetn = 1'b0;
        step("rst_in_exe", OR_, FADD, 0, 1, SIF, 4'b0000, 0, 0);
        resetn = 1'b1;
        step("post_rst_if", OR_, FADD, 0, 1, SIF, 4'b1100, 0, 0);
        step("post_rst_id", OR_, FADD, 0, 1, SID, 4'b0000, 0, 0);
        step("post_rst_exe", OR_, FADD, 0, 1, SEX, 4'b0000, 0, 0);
        step("post_rst_wb", OR_, FADD, 0, 1, SWB, 4'b0001, 0, 0);
        step("post_rst_if2", OR_, FADD, 0, 0, SIF, 4'b0000, 0, 1);

        #20;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
